map_matrix_engine: RTL and testbench
====================================

MAP_MATRIX_ENGINE -- requirements
Module: map_matrix_engine

Interface
REQ-001 SHALL have parameter COLS, default 5, matrix column count (columns a..e).
REQ-002 SHALL have parameter ROWS, default 7, matrix row count (rows 1..7).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clocks per displayed row, >=2.
REQ-004 SHALL have parameter BLINK_FRAMES, default 25, full frames per miss-blink phase, >=1.
REQ-005 SHALL define CELLS=COLS*ROWS; cell index = col*ROWS + row (col 0 = a, row 0 = row 1).
REQ-006 clock  in  1  system clock, all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 load  in  1  one-cycle strobe: capture map_data as a new ship map.
REQ-009 map_data  in  CELLS  ship map, bit=1 ship cell, output format of the existing map decoders.
REQ-010 shot_valid  in  1  shot request, held until accepted.
REQ-011 shot_col  in  clog2(COLS)  shot column.
REQ-012 shot_row  in  clog2(ROWS)  shot row.
REQ-013 shot_ready  out  1  engine accepts a shot this cycle.
REQ-014 result_valid  out  1  one-cycle pulse, shot result present.
REQ-015 result_hit  out  1  shot cell holds a ship; valid with result_valid.
REQ-016 result_repeat  out  1  cell already shot; valid with result_valid.
REQ-017 ships_left  out  clog2(CELLS+1)  unhit ship cells remaining.
REQ-018 game_over  out  1  all ship cells hit.
REQ-019 row_sel  out  ROWS  one-hot active-high row enable.
REQ-020 col_data  out  COLS  active-high pixel data for selected row.

Function
REQ-021 SHALL hold internal registers ship[CELLS], shot[CELLS].
REQ-022 FSM states SHALL be EMPTY, PLAY, CHECK, OVER.
REQ-023 EMPTY: shot_ready=0; load -> capture map_data, clear shot, ships_left=popcount(map_data), next PLAY; if popcount=0 next OVER.
REQ-024 PLAY: shot_ready=1; shot_valid -> latch col/row, next CHECK (accept = shot_valid & shot_ready).
REQ-025 CHECK: shot_ready=0; assert result_valid for exactly this cycle; set shot bit; result_repeat=old shot bit; result_hit=ship bit.
REQ-026 CHECK: ships_left SHALL decrement by 1 only when hit and not repeat; next OVER if it becomes 0, else PLAY.
REQ-027 Shot latency SHALL be 2 cycles: accept at edge N, result_valid high during cycle N+1, shot_ready high again cycle N+2.
REQ-028 Out-of-range coordinate (col>=COLS or row>=ROWS) SHALL return result_hit=0, result_repeat=1, no state change.
REQ-029 OVER: game_over=1, shot_ready=0, shots ignored.
REQ-030 load SHALL be honoured in every state; load in CHECK SHALL cancel the pending result (no result_valid) and restart PLAY with new map.
REQ-031 load and shot_valid same cycle: load wins, shot not accepted.
REQ-032 Scanner: divider counts 0..SCAN_DIV-1; at wrap row index advances, ROWS-1 wraps to 0; free-running in all states.
REQ-033 Frame counter SHALL count row-index wraps; every BLINK_FRAMES frames blink phase toggles.
REQ-034 col_data[c] for current row r SHALL be: shot&ship -> 1; shot&!ship -> blink phase; unshot -> 0; OVER -> ship bit (full map reveal).
REQ-035 row_sel and col_data SHALL be registered (one-cycle lag from row index acceptable, never glitching mid-row).

Reset
REQ-036 reset SHALL force: EMPTY, ship=0, shot=0, ships_left=0, game_over=0, shot_ready=0, result_valid=0, result_hit=0, result_repeat=0.
REQ-037 reset SHALL clear divider, frame counter, blink phase, row index=0; row_sel=1 (row 1), col_data=0 first cycle after.
REQ-038 reset SHALL override load and shot_valid in the same cycle; reset mid-CHECK SHALL suppress result_valid.

Verification
REQ-039 Load map with cells 0,7,33 set -> ships_left=3, shot_ready=1 next cycle; shot (0,0) -> result_hit=1, repeat=0, ships_left=2.
REQ-040 Repeat shot (0,0) -> result_hit=1, result_repeat=1, ships_left unchanged; shot (2,3) on empty cell -> hit=0, repeat=0.
REQ-041 Hit all 3 ships -> game_over=1 cycle after last result, shot_ready=0, further shot_valid yields no result_valid.
REQ-042 Shot accepted then load in CHECK cycle -> no result_valid, ships_left=popcount(new map), shot all 0.
REQ-043 SCAN_DIV=4, BLINK_FRAMES=1: row_sel walks 1,2,..,64(row 7),1 every 4 clocks; a miss cell toggles every 28 clocks.
REQ-044 Load all-zero map -> OVER immediately, game_over=1; reset mid-game -> all REQ-036 values next cycle.

Source files
------------

// File: rtl/map_matrix_engine.sv
// Battleship-style shot engine over a COLS x ROWS ship map, with a multiplexed
// row-scanned LED matrix output that reveals hits, blinks misses and shows the full map at game end.
module map_matrix_engine #(
  parameter int  COLS         = 5,
  parameter int  ROWS         = 7,
  parameter int  SCAN_DIV     = 1000,
  parameter int  BLINK_FRAMES = 25,
  localparam int CELLS        = COLS * ROWS,
  localparam int CW           = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int SW           = $clog2(CELLS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CELLS-1:0] map_data,
  input  logic             shot_valid,
  input  logic [CW-1:0]    shot_col,
  input  logic [RW-1:0]    shot_row,
  output logic             shot_ready,
  output logic             result_valid,
  output logic             result_hit,
  output logic             result_repeat,
  output logic [SW-1:0]    ships_left,
  output logic             game_over,
  output logic [ROWS-1:0]  row_sel,
  output logic [COLS-1:0]  col_data
);

  localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  logic [1:0]       state;
  logic [CELLS-1:0] ship;
  logic [CELLS-1:0] shot;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic             accept;
  logic             in_range;
  logic [IW-1:0]    cell_idx;
  logic             hit_bit;
  logic             old_shot;
  logic [SW-1:0]    load_count;

  function automatic logic [SW-1:0] popcount(input logic [CELLS-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < CELLS; i++) n = n + SW'(v[i]);
    return n;
  endfunction

  assign load_count = popcount(map_data);
  assign shot_ready = (state == PLAY) && !load;
  assign accept     = shot_valid && shot_ready;
  assign game_over  = (state == OVER);

  assign in_range = (32'(col_q) < COLS) && (32'(row_q) < ROWS);
  assign cell_idx = in_range ? IW'(32'(col_q) * ROWS + 32'(row_q)) : '0;
  // Out-of-range coordinates look like an already-shot empty cell.
  assign hit_bit  = in_range && ship[cell_idx];
  assign old_shot = !in_range || shot[cell_idx];

  // A load or reset during the check cycle cancels the pending result.
  assign result_valid  = (state == CHECK) && !load && !reset;
  assign result_hit    = result_valid && hit_bit;
  assign result_repeat = result_valid && old_shot;

  // Stage p0: accepted shot coordinates
  always_ff @(posedge clock) begin
    if (accept) begin
      col_q <= shot_col;
      row_q <= shot_row;
    end
  end

  // Stage p1: game state update
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      ship       <= '0;
      shot       <= '0;
      ships_left <= '0;
    end else if (load) begin
      ship       <= map_data;
      shot       <= '0;
      ships_left <= load_count;
      state      <= (load_count == '0) ? OVER : PLAY;
    end else begin
      case (state)
        PLAY: if (accept) state <= CHECK;
        CHECK: begin
          state <= PLAY;
          if (in_range) begin
            shot[cell_idx] <= 1'b1;
            if (hit_bit && !old_shot) begin
              ships_left <= ships_left - SW'(1);
              if (ships_left == SW'(1)) state <= OVER;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  logic [DW-1:0]   div;
  logic [RW-1:0]   row_idx;
  logic [FW-1:0]   frame_cnt;
  logic            blink;
  logic            div_wrap;
  logic            row_wrap;
  logic [COLS-1:0] pix;
  logic [IW-1:0]   pidx;

  assign div_wrap = (div == DW'(SCAN_DIV - 1));
  assign row_wrap = div_wrap && (row_idx == RW'(ROWS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      div       <= '0;
      row_idx   <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      div <= div_wrap ? '0 : div + DW'(1);
      if (div_wrap) row_idx <= row_wrap ? '0 : row_idx + RW'(1);
      if (row_wrap) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  always_comb begin
    pix  = '0;
    pidx = '0;
    for (int c = 0; c < COLS; c++) begin
      pidx = IW'(c * ROWS + 32'(row_idx));
      if (state == OVER)  pix[c] = ship[pidx];
      else if (shot[pidx]) pix[c] = ship[pidx] ? 1'b1 : blink;
      else                 pix[c] = 1'b0;
    end
  end

  // Stage p2: registered matrix drive, stable for the whole row period
  always_ff @(posedge clock) begin
    if (reset) begin
      row_sel  <= ROWS'(1);
      col_data <= '0;
    end else begin
      row_sel  <= ROWS'(1) << row_idx;
      col_data <= pix;
    end
  end

endmodule

// File: tb/tb_map_matrix_engine.sv
// Scoreboard bench for map_matrix_engine: directed shots with hand-computed results,
// plus scanner, blink and reveal checks on the matrix outputs.
module tb_map_matrix_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [34:0] map_data = '0;
  logic        shot_valid = 1'b0;
  logic [2:0]  shot_col = '0;
  logic [2:0]  shot_row = '0;
  logic        shot_ready;
  logic        result_valid;
  logic        result_hit;
  logic        result_repeat;
  logic [5:0]  ships_left;
  logic        game_over;
  logic [6:0]  row_sel;
  logic [4:0]  col_data;

  typedef struct packed {
    logic hit;
    logic rep;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  localparam logic [34:0] MAP3 = (35'd1 << 0) | (35'd1 << 7) | (35'd1 << 33);
  localparam logic [34:0] MAP4 = (35'd1 << 10) | (35'd1 << 20) | (35'd1 << 30) | (35'd1 << 34);

  map_matrix_engine #(
    .COLS(5), .ROWS(7), .SCAN_DIV(4), .BLINK_FRAMES(1)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .map_data(map_data),
    .shot_valid(shot_valid), .shot_col(shot_col), .shot_row(shot_row),
    .shot_ready(shot_ready), .result_valid(result_valid), .result_hit(result_hit),
    .result_repeat(result_repeat), .ships_left(ships_left), .game_over(game_over),
    .row_sel(row_sel), .col_data(col_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result_hit", result_hit, e.hit);
        chk("result_repeat", result_repeat, e.rep);
      end
    end
  end

  task automatic load_map(input logic [34:0] m);
    @(posedge clock); #1;
    load = 1'b1;
    map_data = m;
    @(posedge clock); #1;
    load = 1'b0;
  endtask

  task automatic shoot(input int c, input int r, input logic h, input logic rp);
    bit done;
    done = 0;
    sb.push_back('{hit: h, rep: rp});
    @(posedge clock); #1;
    shot_valid = 1'b1;
    shot_col = 3'(c);
    shot_row = 3'(r);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clock);
      if (shot_ready) begin
        @(posedge clock); #1;
        shot_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      shot_valid = 1'b0;
      void'(sb.pop_back());
      chk("shot_accept_timeout", 0, 1);
    end else begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_row(input logic [6:0] sel, input logic [4:0] exp_cols, input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clock);
      if (row_sel == sel) begin
        chk(name, col_data, exp_cols);
        seen = 1;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          last_start;
    int          wins;
    logic        prev_val;
    logic [6:0]  prev_sel;

    // Reset overrides a simultaneous load and shot.
    reset = 1'b1; load = 1'b1; map_data = '1; shot_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; load = 1'b0; shot_valid = 1'b0; map_data = '0;
    @(negedge clock);
    chk("rst_shot_ready", shot_ready, 0);
    chk("rst_ships_left", ships_left, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_row_sel", row_sel, 7'd1);
    chk("rst_col_data", col_data, 0);

    load_map(MAP3);
    @(negedge clock);
    chk("load_ships_left", ships_left, 3);
    chk("load_shot_ready", shot_ready, 1);

    shoot(0, 0, 1'b1, 1'b0);
    @(negedge clock); chk("first_hit_ships_left", ships_left, 2);
    shoot(0, 0, 1'b1, 1'b1);
    @(negedge clock); chk("repeat_ships_left", ships_left, 2);
    shoot(2, 3, 1'b0, 1'b0);
    @(negedge clock); chk("miss_ships_left", ships_left, 2);
    shoot(5, 0, 1'b0, 1'b1);
    shoot(0, 7, 1'b0, 1'b1);
    @(negedge clock); chk("oor_ships_left", ships_left, 2);
    chk("oor_shot_ready", shot_ready, 1);

    // Miss at (2,3) blinks once per 28-clock frame; hit at (0,0) stays lit.
    cyc = 0; last_start = 0; wins = 0; prev_val = 1'b0; prev_sel = '0;
    for (int n = 0; n < 150 && wins < 4; n++) begin
      @(negedge clock);
      cyc++;
      if (row_sel == 7'd8 && prev_sel != 7'd8) begin
        if (wins > 0) begin
          chk("blink_period", cyc - last_start, 28);
          chk("blink_toggle", col_data[2], !prev_val);
        end
        prev_val = col_data[2];
        last_start = cyc;
        wins++;
      end
      if (row_sel == 7'd1 && prev_sel != 7'd1) chk("row1_pixels", col_data, 5'b00001);
      prev_sel = row_sel;
    end
    chk("blink_windows_seen", wins, 4);

    shoot(1, 0, 1'b1, 1'b0);
    @(negedge clock); chk("second_hit_ships_left", ships_left, 1);
    shoot(4, 5, 1'b1, 1'b0);
    @(negedge clock);
    chk("final_ships_left", ships_left, 0);
    chk("over_game_over", game_over, 1);
    chk("over_shot_ready", shot_ready, 0);

    // Shots in OVER are ignored; the monitor flags any result pulse.
    @(posedge clock); #1;
    shot_valid = 1'b1; shot_col = 3'd2; shot_row = 3'd2;
    repeat (6) begin
      @(negedge clock);
      chk("over_ready_held_low", shot_ready, 0);
    end
    @(posedge clock); #1;
    shot_valid = 1'b0;
    wait_row(7'd1, 5'b00011, "reveal_row1");
    wait_row(7'd32, 5'b10000, "reveal_row6");

    // Load during the check cycle cancels the result and installs the new map.
    load_map(MAP3);
    @(posedge clock); #1;
    shot_valid = 1'b1; shot_col = 3'd0; shot_row = 3'd0;
    @(negedge clock);
    chk("cancel_ready_before", shot_ready, 1);
    @(posedge clock); #1;
    shot_valid = 1'b0;
    load = 1'b1; map_data = MAP4;
    @(posedge clock); #1;
    load = 1'b0;
    @(negedge clock);
    chk("cancel_ships_left", ships_left, 4);
    chk("cancel_shot_ready", shot_ready, 1);
    chk("cancel_game_over", game_over, 0);
    shoot(0, 0, 1'b0, 1'b0);
    shoot(1, 3, 1'b1, 1'b0);
    @(negedge clock); chk("newmap_ships_left", ships_left, 3);

    load_map('0);
    @(negedge clock);
    chk("zero_map_game_over", game_over, 1);
    chk("zero_map_ships_left", ships_left, 0);
    chk("zero_map_shot_ready", shot_ready, 0);

    // Load and shot in the same cycle: only the load takes effect.
    @(posedge clock); #1;
    load = 1'b1; map_data = 35'd1;
    @(posedge clock); #1;
    load = 1'b0;
    @(posedge clock); #1;
    load = 1'b1; map_data = 35'd1 | (35'd1 << 7);
    shot_valid = 1'b1; shot_col = 3'd0; shot_row = 3'd0;
    @(posedge clock); #1;
    load = 1'b0; shot_valid = 1'b0;
    @(negedge clock);
    chk("loadwins_ships_left", ships_left, 2);
    chk("loadwins_shot_ready", shot_ready, 1);
    shoot(0, 0, 1'b1, 1'b0);
    @(negedge clock); chk("loadwins_after_ships_left", ships_left, 1);

    // Reset in the check cycle suppresses the result.
    @(posedge clock); #1;
    shot_valid = 1'b1; shot_col = 3'd1; shot_row = 3'd0;
    @(negedge clock);
    chk("midreset_ready_before", shot_ready, 1);
    @(posedge clock); #1;
    shot_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_shot_ready", shot_ready, 0);
    chk("midreset_ships_left", ships_left, 0);
    chk("midreset_game_over", game_over, 0);
    chk("midreset_row_sel", row_sel, 7'd1);
    chk("midreset_col_data", col_data, 0);

    // Row scan after reset: one-cycle register lag, 4 clocks per row, 7 rows.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      chk("scan_row_sel", row_sel, 7'd1 << (((k - 1) / 4) % 7));
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
